// File: rtl/upscale_frame_sequencer_if.sv
// Signal bundle between the frame sequencer, the pixel source and the upscaler datapath.
interface upscale_frame_sequencer_if;
  logic        start;
  logic [23:0] s_pixel;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] dp_pixel;
  logic        dp_valid;
  logic [1:0]  dp_h_phase;
  logic [1:0]  dp_v_phase;
  logic        m_sof;
  logic        m_eol;
  logic        busy;
  logic        frame_done;

  modport master (
    input  start, s_pixel, s_valid,
    output s_ready, dp_pixel, dp_valid, dp_h_phase, dp_v_phase,
           m_sof, m_eol, busy, frame_done
  );

  modport slave (
    output start, s_pixel, s_valid,
    input  s_ready, dp_pixel, dp_valid, dp_h_phase, dp_v_phase,
           m_sof, m_eol, busy, frame_done
  );
endinterface

// File: rtl/upscale_frame_sequencer.sv
// Frame sequencer for the bicubic upscaler: holds each source pixel for SCALE phases,
// buffers the source row and replays it for the remaining vertical phases.
module upscale_frame_sequencer #(
  parameter int unsigned IMG_W    = 384,
  parameter int unsigned IMG_H    = 216,
  parameter int unsigned SCALE    = 3,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  upscale_frame_sequencer_if.master bus
);
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned FW = $clog2(PIPE_LAT + 1) + 1;

  localparam logic [1:0]    PH_LAST  = 2'(SCALE - 1);
  localparam logic [1:0]    PH_PREF  = 2'(SCALE - 2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(PIPE_LAT);

  typedef enum logic [2:0] {IDLE, LIVE, PRIME, REPLAY, FLUSH, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    h, v;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] fl_cnt;

  logic          s_ready, accept, issue, h_wrap, row_done, v_wrap;
  logic          busy, frame_done;
  logic          rd_en;
  logic [CW-1:0] rd_addr;

  logic [23:0]   row_buf [IMG_W];
  logic [23:0]   rd_data;

  logic [23:0]   dp_pixel;
  logic          dp_valid;
  logic [1:0]    dp_h_phase, dp_v_phase;
  logic          sof_q, eol_q;
  logic [PIPE_LAT-1:0] sof_sr, eol_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    s_ready    = (state == LIVE) && (h == '0);
    accept     = s_ready && bus.s_valid;
    issue      = (state == REPLAY) || ((state == LIVE) && ((h != '0) || bus.s_valid));
    h_wrap     = issue && (h == PH_LAST);
    row_done   = h_wrap && (col == COL_LAST);
    v_wrap     = row_done && (v == PH_LAST);
    busy       = (state != IDLE) && (state != DONE);
    frame_done = (state == DONE);
    // Next column is fetched one phase ahead so it is ready at its h==0 cycle.
    rd_en      = (state == PRIME) || ((state == REPLAY) && (h == PH_PREF));
    rd_addr    = ((state == PRIME) || (col == COL_LAST)) ? '0 : col + CW'(1);
    state_nxt  = state;
    case (state)
      IDLE:        if (bus.start) state_nxt = LIVE;
      LIVE, REPLAY: if (row_done) begin
        if (!v_wrap)              state_nxt = PRIME;
        else if (row == ROW_LAST) state_nxt = FLUSH;
        else                      state_nxt = LIVE;
      end
      PRIME:       state_nxt = REPLAY;
      // One extra cycle beyond PIPE_LAT covers the registered dp stage.
      FLUSH:       if (fl_cnt == FL_LAST) state_nxt = DONE;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h      <= '0;
      v      <= '0;
      col    <= '0;
      row    <= '0;
      fl_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        h   <= '0;
        v   <= '0;
        col <= '0;
        row <= '0;
      end else if (issue) begin
        h <= h_wrap ? '0 : h + 2'd1;
        if (h_wrap)   col <= row_done ? '0 : col + CW'(1);
        if (row_done) v   <= v_wrap ? '0 : v + 2'd1;
        if (v_wrap)   row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end
      fl_cnt <= (state == FLUSH) ? fl_cnt + FW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) row_buf[col] <= bus.s_pixel;
    if (rd_en)  rd_data      <= row_buf[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_pixel   <= '0;
      dp_valid   <= 1'b0;
      dp_h_phase <= '0;
      dp_v_phase <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      sof_sr     <= '0;
      eol_sr     <= '0;
    end else begin
      dp_valid   <= issue;
      dp_h_phase <= h;
      dp_v_phase <= v;
      if (accept)                                dp_pixel <= bus.s_pixel;
      else if ((state == REPLAY) && (h == '0))   dp_pixel <= rd_data;
      sof_q      <= issue && (row == '0) && (v == '0) && (col == '0) && (h == '0);
      eol_q      <= row_done;
      sof_sr[0]  <= sof_q;
      eol_sr[0]  <= eol_q;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        sof_sr[i] <= sof_sr[i-1];
        eol_sr[i] <= eol_sr[i-1];
      end
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.dp_pixel   = dp_pixel;
  assign bus.dp_valid   = dp_valid;
  assign bus.dp_h_phase = dp_h_phase;
  assign bus.dp_v_phase = dp_v_phase;
  assign bus.m_sof      = sof_sr[PIPE_LAT-1];
  assign bus.m_eol      = eol_sr[PIPE_LAT-1];
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
endmodule
